// File: rtl/rv_rsp_reorder_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv_rsp_reorder_buffer_pkg
//  Purpose  : Shared definitions for the response reorder buffer slice.
//             Provides the tag-width derivation used by the interface, the
//             order FIFO and the top level so all agree on ADDRW.
//  Contents : tag_width(size) -> number of bits needed to index 'size' tags
//             (never less than 1, so a single-tag build still has a port).
//  Revision : 1.0  initial release
// ============================================================================
package rv_rsp_reorder_buffer_pkg;

    function automatic int tag_width(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv_rsp_reorder_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : rv_rsp_reorder_buffer_if
//  Purpose  : Bundles the issue, response, ordered-output and tag-release
//             signals of the reorder buffer.
//  Modports : slave  - the reorder buffer itself
//             master - the surrounding pipeline / testbench
//  Signals  : issue_valid/issue_tag/issue_ready  tag issue handshake
//             rsp_valid/rsp_tag/rsp_data         out-of-order responses
//             out_valid/out_tag/out_data/out_ready  in-order retirement
//             release_slot/release_addr          tag return pulse
//             empty/full                         occupancy status
//  Revision : 1.0  initial release
// ============================================================================
interface rv_rsp_reorder_buffer_if #(
    parameter int DATAW = 32,
    parameter int ADDRW = 2
);
    logic             issue_valid;
    logic [ADDRW-1:0] issue_tag;
    logic             issue_ready;
    logic             rsp_valid;
    logic [ADDRW-1:0] rsp_tag;
    logic [DATAW-1:0] rsp_data;
    logic             out_valid;
    logic [ADDRW-1:0] out_tag;
    logic [DATAW-1:0] out_data;
    logic             out_ready;
    logic             release_slot;
    logic [ADDRW-1:0] release_addr;
    logic             empty;
    logic             full;

    modport slave (
        input  issue_valid, issue_tag, rsp_valid, rsp_tag, rsp_data, out_ready,
        output issue_ready, out_valid, out_tag, out_data, release_slot,
               release_addr, empty, full
    );

    modport master (
        output issue_valid, issue_tag, rsp_valid, rsp_tag, rsp_data, out_ready,
        input  issue_ready, out_valid, out_tag, out_data, release_slot,
               release_addr, empty, full
    );
endinterface
`default_nettype wire

// File: rtl/rv_tag_order_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : rv_tag_order_fifo
//  Purpose  : Circular queue recording the order in which tags were issued.
//             Head is always visible combinationally; no write-to-read bypass,
//             so a pushed tag appears at the head one cycle later at earliest.
//  Ports    : clk, reset (async, active-low)
//             i_push/i_push_tag  append a tag (caller guarantees !o_full)
//             i_pop              drop the head (caller guarantees !o_empty)
//             o_head             oldest tag
//             o_count            occupancy, 0..SIZE
//             o_empty/o_full     occupancy status from the count register
//  Revision : 1.0  initial release
// ============================================================================
module rv_tag_order_fifo #(
    parameter int SIZE  = 4,
    parameter int ADDRW = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [ADDRW-1:0] i_push_tag,
    input  logic             i_pop,
    output logic [ADDRW-1:0] o_head,
    output logic [ADDRW:0]   o_count,
    output logic             o_empty,
    output logic             o_full
);
    localparam logic [ADDRW-1:0] c_LAST = ADDRW'(SIZE - 1);
    localparam logic [ADDRW:0]   c_FULL = (ADDRW + 1)'(SIZE);

    logic [ADDRW-1:0] r_order [SIZE];
    logic [ADDRW-1:0] r_rd_ptr;
    logic [ADDRW-1:0] r_wr_ptr;
    logic [ADDRW:0]   r_count;

    // Explicit wrap keeps non-power-of-two SIZE correct.
    function automatic logic [ADDRW-1:0] ptr_inc(input logic [ADDRW-1:0] p);
        return (p == c_LAST) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < SIZE; i++) begin
                r_order[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_order[r_wr_ptr] <= i_push_tag;
                r_wr_ptr          <= ptr_inc(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_order[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_FULL);
endmodule
`default_nettype wire

// File: rtl/rv_rsp_reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : rv_rsp_reorder_buffer
//  Purpose  : Accepts tagged responses in any order and retires them in the
//             order their tags were issued, returning each retired tag to the
//             index buffer with a one-cycle release pulse.
//  Ports    : clk    rising-edge clock
//             reset  asynchronous, active-low reset
//             bus    rv_rsp_reorder_buffer_if.slave (issue, response, ordered
//                    output, release pulse and empty/full status)
//  Revision : 1.0  initial release
// ============================================================================
module rv_rsp_reorder_buffer
    import rv_rsp_reorder_buffer_pkg::*;
#(
    parameter int DATAW = 32,
    parameter int SIZE  = 4,
    parameter int ADDRW = tag_width(SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    rv_rsp_reorder_buffer_if.slave bus
);
    logic [ADDRW-1:0] w_head_tag;
    logic [ADDRW:0]   w_count;
    logic             w_empty;
    logic             w_full;
    logic             w_issue_fire;
    logic             w_out_valid;
    logic             w_pop;

    logic [SIZE-1:0]  r_done;
    logic [DATAW-1:0] r_data [SIZE];
    logic             r_release_slot;
    logic [ADDRW-1:0] r_release_addr;

    // Ready comes from the pre-pop occupancy: a full queue refuses an issue
    // even in the cycle it retires an entry.
    assign w_issue_fire = bus.issue_valid && !w_full;
    assign w_out_valid  = !w_empty && r_done[w_head_tag];
    assign w_pop        = w_out_valid && bus.out_ready;

    rv_tag_order_fifo #(
        .SIZE  (SIZE),
        .ADDRW (ADDRW)
    ) u_order (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_issue_fire),
        .i_push_tag (bus.issue_tag),
        .i_pop      (w_pop),
        .o_head     (w_head_tag),
        .o_count    (w_count),
        .o_empty    (w_empty),
        .o_full     (w_full)
    );

    // A response and a pop only ever target different tags in legal traffic,
    // so the response set is placed after the pop clear purely for clarity.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done         <= '0;
            r_release_slot <= 1'b0;
            r_release_addr <= '0;
            for (int i = 0; i < SIZE; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            if (w_pop) begin
                r_done[w_head_tag] <= 1'b0;
            end
            if (bus.rsp_valid) begin
                r_done[bus.rsp_tag] <= 1'b1;
                r_data[bus.rsp_tag] <= bus.rsp_data;
            end
            r_release_slot <= w_pop;
            if (w_pop) begin
                r_release_addr <= w_head_tag;
            end
        end
    end

    assign bus.issue_ready  = !w_full;
    assign bus.out_valid    = w_out_valid;
    assign bus.out_tag      = w_head_tag;
    assign bus.out_data     = r_data[w_head_tag];
    assign bus.release_slot = r_release_slot;
    assign bus.release_addr = r_release_addr;
    assign bus.empty        = w_empty;
    assign bus.full         = w_full;

`ifndef SYNTHESIS
    // Tags currently in the order queue, for protocol checking only.
    logic [SIZE-1:0] r_pending;
    logic            w_rsp_legal;
    logic [ADDRW:0]  w_count_unused;

    assign w_count_unused = w_count;
    assign w_rsp_legal = !r_done[bus.rsp_tag] &&
                         (r_pending[bus.rsp_tag] ||
                          (w_issue_fire && (bus.issue_tag == bus.rsp_tag)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
        end else begin
            if (w_pop) begin
                r_pending[w_head_tag] <= 1'b0;
            end
            if (w_issue_fire) begin
                r_pending[bus.issue_tag] <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            // Dropping an issue is flow control the producer must retry.
            assert (!(bus.issue_valid && w_full))
                else $warning("issue of tag %0d dropped: order queue full", bus.issue_tag);
            if (bus.rsp_valid) begin
                assert (w_rsp_legal)
                    else $error("illegal response to tag %0d (already done or not outstanding)",
                                bus.rsp_tag);
            end
        end
    end
`endif
endmodule
`default_nettype wire

// File: tb/tb_rv_rsp_reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv_rsp_reorder_buffer
//  Purpose  : Self-checking bench for rv_rsp_reorder_buffer. A reference
//             queue of issued tags plus per-tag done/data records predicts
//             every output; a vector table covers the ordered and reordered
//             retirement cases, hand sequences cover wrap, backpressure and
//             asynchronous reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rv_rsp_reorder_buffer;
    localparam int c_DATAW = 32;
    localparam int c_SIZE  = 4;
    localparam int c_ADDRW = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    rv_rsp_reorder_buffer_if #(.DATAW(c_DATAW), .ADDRW(c_ADDRW)) bus ();

    rv_rsp_reorder_buffer #(
        .DATAW (c_DATAW),
        .SIZE  (c_SIZE),
        .ADDRW (c_ADDRW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          iv;
        int          itag;
        bit          rv;
        int          rtag;
        logic [31:0] rdat;
        bit          ordy;
        int          ev;     // expected out_valid before this row is driven
        int          erel;   // expected release_slot before this row is driven
    } vec_t;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          order_q[$];
    bit          m_done [c_SIZE];
    logic [31:0] m_data [c_SIZE];
    bit          exp_rel;
    int          exp_rel_addr;
    vec_t        tbl [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input bit iv, input int itag, input bit rv, input int rtag,
                                input logic [31:0] rdat, input bit ordy, input int ev,
                                input int erel);
        vec_t v;
        v.iv = iv; v.itag = itag; v.rv = rv; v.rtag = rtag;
        v.rdat = rdat; v.ordy = ordy; v.ev = ev; v.erel = erel;
        return v;
    endfunction

    task automatic model_clear();
        order_q.delete();
        for (int i = 0; i < c_SIZE; i++) begin
            m_done[i] = 1'b0;
            m_data[i] = '0;
        end
        exp_rel      = 1'b0;
        exp_rel_addr = 0;
    endtask

    task automatic drive_idle();
        bus.issue_valid = 1'b0;
        bus.issue_tag   = '0;
        bus.rsp_valid   = 1'b0;
        bus.rsp_tag     = '0;
        bus.rsp_data    = '0;
        bus.out_ready   = 1'b0;
    endtask

    // One clock: check outputs at the falling edge, drive the new inputs,
    // advance the reference model to what the next rising edge will do.
    task automatic step(input bit iv, input int itag, input bit rv, input int rtag,
                        input logic [31:0] rdat, input bit ordy, input int tv, input int trel);
        int head;
        bit mv;
        bit pop;
        bit acc;
        @(negedge clk);
        head = (order_q.size() != 0) ? order_q[0] : 0;
        mv   = (order_q.size() != 0) && m_done[head];
        chk("out_valid", bus.out_valid, mv);
        if (mv) begin
            chk("out_tag", bus.out_tag, head);
            chk("out_data", bus.out_data, m_data[head]);
        end
        chk("empty", bus.empty, order_q.size() == 0);
        chk("full", bus.full, order_q.size() == c_SIZE);
        chk("issue_ready", bus.issue_ready, order_q.size() != c_SIZE);
        chk("release_slot", bus.release_slot, exp_rel);
        if (exp_rel) begin
            chk("release_addr", bus.release_addr, exp_rel_addr);
        end
        if (tv >= 0) chk("tbl_out_valid", bus.out_valid, tv[0]);
        if (trel >= 0) chk("tbl_release", bus.release_slot, trel[0]);

        bus.issue_valid = iv;
        bus.issue_tag   = c_ADDRW'(itag);
        bus.rsp_valid   = rv;
        bus.rsp_tag     = c_ADDRW'(rtag);
        bus.rsp_data    = rdat;
        bus.out_ready   = ordy;

        pop = mv && ordy;
        acc = iv && (order_q.size() < c_SIZE);
        exp_rel = pop;
        if (pop) begin
            exp_rel_addr = head;
            void'(order_q.pop_front());
            m_done[head] = 1'b0;
        end
        if (rv) begin
            m_done[rtag] = 1'b1;
            m_data[rtag] = rdat;
        end
        if (acc) order_q.push_back(itag);
        @(posedge clk);
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 0, 1'b0, 0, 32'h0, ordy, -1, -1);
    endtask

    // Drops reset between edges and checks that outputs clear immediately.
    task automatic reset_pulse();
        reset = 1'b0;
        drive_idle();
        model_clear();
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_tag", bus.out_tag, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_empty", bus.empty, 1'b1);
        chk("rst_full", bus.full, 1'b0);
        chk("rst_issue_ready", bus.issue_ready, 1'b1);
        chk("rst_release_slot", bus.release_slot, 1'b0);
        chk("rst_release_addr", bus.release_addr, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        // In-order: tags 0,1 answered in order.
        tbl[0]  = mk(1, 0, 0, 0, 32'h00, 1, 0, 0);
        tbl[1]  = mk(1, 1, 1, 0, 32'hA0, 1, 0, 0);
        tbl[2]  = mk(0, 0, 1, 1, 32'hA1, 1, 1, 0);
        tbl[3]  = mk(0, 0, 0, 0, 32'h00, 1, 1, 1);
        tbl[4]  = mk(0, 0, 0, 0, 32'h00, 1, 0, 1);
        tbl[5]  = mk(0, 0, 0, 0, 32'h00, 1, 0, 0);
        // Out-of-order: issue 2,0,3; answer 3 (same edge as its issue), 0, 2.
        tbl[6]  = mk(1, 2, 0, 0, 32'h00, 1, 0, 0);
        tbl[7]  = mk(1, 0, 0, 0, 32'h00, 1, 0, 0);
        tbl[8]  = mk(1, 3, 1, 3, 32'h33, 1, 0, 0);
        tbl[9]  = mk(0, 0, 1, 0, 32'h00, 1, 0, 0);
        tbl[10] = mk(0, 0, 1, 2, 32'h22, 1, 0, 0);
        tbl[11] = mk(0, 0, 0, 0, 32'h00, 1, 1, 0);
        tbl[12] = mk(0, 0, 0, 0, 32'h00, 1, 1, 1);
        tbl[13] = mk(0, 0, 0, 0, 32'h00, 1, 1, 1);
        tbl[14] = mk(0, 0, 0, 0, 32'h00, 1, 0, 1);
        tbl[15] = mk(0, 0, 0, 0, 32'h00, 1, 0, 0);

        drive_idle();
        model_clear();
        #3;
        reset_pulse();

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].iv, tbl[i].itag, tbl[i].rv, tbl[i].rtag, tbl[i].rdat,
                 tbl[i].ordy, tbl[i].ev, tbl[i].erel);
        end

        // Full / wrap: three rounds of five pushes each so both pointers wrap.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < c_SIZE; k++) step(1'b1, (k + r) % c_SIZE, 1'b0, 0, 32'h0, 1'b0, -1, -1);
            for (int k = c_SIZE - 1; k >= 0; k--)
                step(1'b0, 0, 1'b1, (k + r) % c_SIZE, 32'hC0 + 32'h100 * r + k, 1'b0, -1, -1);
            // Pop while full with an issue offered: issue refused this cycle.
            step(1'b1, r % c_SIZE, 1'b0, 0, 32'h0, 1'b1, -1, -1);
            // Same issue offered again: accepted now.
            step(1'b1, r % c_SIZE, 1'b0, 0, 32'h0, 1'b0, -1, -1);
            step(1'b0, 0, 1'b1, r % c_SIZE, 32'hE0 + r, 1'b0, -1, -1);
            for (int k = 0; k < c_SIZE; k++) idle(1'b1);
            idle(1'b0);
        end

        // Backpressure: head valid, held for five cycles, then a single pop.
        step(1'b1, 1, 1'b0, 0, 32'h0, 1'b0, -1, -1);
        step(1'b0, 0, 1'b1, 1, 32'hBB, 1'b0, -1, -1);
        for (int k = 0; k < 5; k++) step(1'b0, 0, 1'b0, 0, 32'h0, 1'b0, 1, 0);
        idle(1'b1);
        step(1'b0, 0, 1'b0, 0, 32'h0, 1'b0, 0, 1);
        step(1'b0, 0, 1'b0, 0, 32'h0, 1'b0, 0, 0);

        // Async reset with three outstanding and the head answered.
        step(1'b1, 0, 1'b0, 0, 32'h0, 1'b0, -1, -1);
        step(1'b1, 1, 1'b0, 0, 32'h0, 1'b0, -1, -1);
        step(1'b1, 2, 1'b1, 0, 32'h77, 1'b0, -1, -1);
        step(1'b0, 0, 1'b0, 0, 32'h0, 1'b0, 1, 0);
        @(negedge clk);
        #2;
        reset_pulse();
        step(1'b1, 0, 1'b0, 0, 32'h0, 1'b0, 0, 0);
        step(1'b0, 0, 1'b1, 0, 32'h5A, 1'b0, 0, 0);
        step(1'b0, 0, 1'b0, 0, 32'h0, 1'b1, 1, 0);
        step(1'b0, 0, 1'b0, 0, 32'h0, 1'b0, 0, 1);
        idle(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
